// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES request sequencer: operand widths, command and status codes, FSM states.
package aes_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int BLK_W  = 128;

  localparam logic [WORD_W-1:0] CMD_SET_KEY = 32'h0000_0001;
  localparam logic [WORD_W-1:0] CMD_ENCRYPT = 32'h0000_0002;
  localparam logic [WORD_W-1:0] CMD_DECRYPT = 32'h0000_0003;

  localparam logic [1:0] AES_ST_OK      = 2'd0;
  localparam logic [1:0] AES_ST_BADCMD  = 2'd1;
  localparam logic [1:0] AES_ST_NOKEY   = 2'd2;
  localparam logic [1:0] AES_ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic cmd_known(input logic [WORD_W-1:0] c);
    return (c == CMD_SET_KEY) || (c == CMD_ENCRYPT) || (c == CMD_DECRYPT);
  endfunction

endpackage

// File: rtl/aes_ctrl_timer.sv
// Load/run/expire down-counter bounding how long the sequencer waits for the core.
module aes_ctrl_timer #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  // Loaded with CYCLES-1 so expiry lands on the CYCLES-th running cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (load)                count <= CW'(CYCLES - 1);
    else if (run && count != '0)  count <= count - 1'b1;
  end

  assign expire = run && (count == '0);

endmodule

// File: rtl/aes_ctrl.sv
// Command sequencer for the AES core: accepts one request, launches it, returns result + status.
// Optional wait watchdog compiled in with AES_CTRL_WATCHDOG_EN.
module aes_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_cmd,
  input  logic [KEY_W-1:0]  s_key,
  input  logic [BLK_W-1:0]  s_blk,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BLK_W-1:0]  m_blk,
  output logic [1:0]        m_status,
  output logic              key_valid,
  output logic              aes_en,
  output logic [WORD_W-1:0] aes_cmd,
  output logic [KEY_W-1:0]  aes_key,
  output logic [BLK_W-1:0]  aes_in_blk,
  input  logic [BLK_W-1:0]  aes_out_blk,
  input  logic              aes_en_o
);

  state_e state;
  logic   launch_ok;
  logic   wd_expire;

  // Launch decision looks only at registered operands, never at the request port.
  assign launch_ok = cmd_known(aes_cmd) && ((aes_cmd == CMD_SET_KEY) || key_valid);
  assign aes_en    = (state == ST_ISSUE) && launch_ok;

`ifdef AES_CTRL_WATCHDOG_EN
  aes_ctrl_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (aes_en),
    .run    (state == ST_WAIT),
    .expire (wd_expire)
  );
`else
  // Never expires; the parameter stays so instantiations do not depend on the build.
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_blk      <= '0;
      m_status   <= AES_ST_OK;
      key_valid  <= 1'b0;
      aes_cmd    <= '0;
      aes_key    <= '0;
      aes_in_blk <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            aes_cmd    <= s_cmd;
            aes_key    <= s_key;
            aes_in_blk <= s_blk;
            s_ready    <= 1'b0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!cmd_known(aes_cmd)) begin
            m_status <= AES_ST_BADCMD;
            m_blk    <= '0;
            m_valid  <= 1'b1;
            state    <= ST_RESP;
          end else if (!launch_ok) begin
            m_status <= AES_ST_NOKEY;
            m_blk    <= '0;
            m_valid  <= 1'b1;
            state    <= ST_RESP;
          end else begin
            // Round-key RAM is about to be overwritten.
            if (aes_cmd == CMD_SET_KEY) key_valid <= 1'b0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (aes_en_o) begin
            m_status <= AES_ST_OK;
            m_blk    <= (aes_cmd == CMD_SET_KEY) ? '0 : aes_out_blk;
            if (aes_cmd == CMD_SET_KEY) key_valid <= 1'b1;
            m_valid  <= 1'b1;
            state    <= ST_RESP;
          end else if (wd_expire) begin
            m_status <= AES_ST_TIMEOUT;
            m_blk    <= '0;
            m_valid  <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctrl.sv
// Scoreboard bench for aes_ctrl: random requests, a core model with random latency, queued expectations.
module tb_aes_ctrl;
  import aes_ctrl_pkg::*;

  localparam int TO = 8;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0, rst = 1'b1;
  logic         s_valid = 1'b0, s_ready;
  logic [31:0]  s_cmd = '0;
  logic [127:0] s_key = '0, s_blk = '0;
  logic         m_valid, m_ready = 1'b0;
  logic [127:0] m_blk;
  logic [1:0]   m_status;
  logic         key_valid, aes_en;
  logic [31:0]  aes_cmd;
  logic [127:0] aes_key, aes_in_blk;
  logic [127:0] core_out = '0;
  logic         core_done = 1'b0, spur_done = 1'b0, done_w;

  assign done_w = core_done | spur_done;

  aes_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_key(s_key), .s_blk(s_blk),
    .m_valid(m_valid), .m_ready(m_ready), .m_blk(m_blk), .m_status(m_status),
    .key_valid(key_valid), .aes_en(aes_en), .aes_cmd(aes_cmd), .aes_key(aes_key),
    .aes_in_blk(aes_in_blk), .aes_out_blk(core_out), .aes_en_o(done_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stand-in cipher: exact FIPS-197 vectors, otherwise an invertible toy transform.
  function automatic logic [127:0] cipher(input bit enc, input logic [127:0] k, input logic [127:0] b);
    logic [127:0] t;
    if (k == FK && enc && b == FP) return FC;
    if (k == FK && !enc && b == FC) return FP;
    if (enc) begin
      t = b ^ k;
      return {t[119:0], t[127:120]};
    end
    t = {b[7:0], b[127:8]};
    return t ^ k;
  endfunction

  // ---------------- core model ----------------
  bit           core_hang = 0;
  int           core_n_force = 0;
  int           core_cnt = 0, en_cyc = 0, done_cyc = 0;
  bit           core_busy = 0;
  logic [127:0] core_key = '0, core_res = '0;

  initial begin
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        core_busy = 0;
        core_key  = '0;
      end else begin
        if (core_busy) begin
          core_cnt--;
          if (core_cnt == 0) begin
            core_busy = 0;
            core_done = 1'b1;
            core_out  = core_res;
            done_cyc  = cyc;
          end
        end
        if (aes_en) begin
          en_cyc    = cyc;
          core_busy = !core_hang;
          core_cnt  = (core_n_force != 0) ? core_n_force : int'($urandom_range(1, 5));
          if (aes_cmd == CMD_SET_KEY) begin
            core_key = aes_key;
            core_res = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            core_res = cipher(aes_cmd == CMD_ENCRYPT, core_key, aes_in_blk);
          end
        end
      end
    end
  end

  // ---------------- response-ready driver ----------------
  int rdy_mode = 1;  // 0 random, 1 always high, 2 held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'($urandom_range(0, 1));
        1:       m_ready = 1'b1;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [1:0]   st;
    logic [127:0] blk;
    logic         kv;
    int           en;
    bit           launch;
    bit           tmo;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  bit           m_kv = 0;
  logic [127:0] m_key = '0;
  int           m_launches = 0;

  function automatic exp_t model(input logic [31:0] cmd, input logic [127:0] key, input logic [127:0] blk);
    exp_t e;
    e.st = AES_ST_OK; e.blk = '0; e.launch = 0; e.tmo = 0; e.acc = cyc;
    if (!(cmd == CMD_SET_KEY || cmd == CMD_ENCRYPT || cmd == CMD_DECRYPT)) begin
      e.st = AES_ST_BADCMD;
    end else if (cmd != CMD_SET_KEY && !m_kv) begin
      e.st = AES_ST_NOKEY;
    end else begin
      e.launch = 1;
      m_launches++;
      if (cmd == CMD_SET_KEY) m_kv = 0;
      if (core_hang) begin
        e.tmo = 1;
        e.st  = AES_ST_TIMEOUT;
      end else if (cmd == CMD_SET_KEY) begin
        m_kv  = 1;
        m_key = key;
      end else begin
        e.blk = cipher(cmd == CMD_ENCRYPT, m_key, blk);
      end
    end
    e.kv = m_kv;
    e.en = m_launches;
    return e;
  endfunction

  int           en_cnt = 0, mv_rise = 0;
  bit           pmv = 0, pmr = 0;
  logic [127:0] pblk = '0;
  logic [1:0]   pst = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmv = 0; pmr = 0;
      end else begin
        if (pmv && pmr) chk("s_ready_after_hs", s_ready, 1);
        if (pmv && !pmr) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_blk", m_blk, pblk);
          chk("hold_status", m_status, pst);
        end
        if (m_valid) chk("s_ready_in_resp", s_ready, 0);
        if (aes_en) en_cnt++;
        if (m_valid && !pmv) mv_rise = cyc;
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_resp: got status %0d with no request pending", m_status);
          end else begin
            e = sbq.pop_front();
            chk("status", m_status, e.st);
            chk("blk", m_blk, e.blk);
            chk("key_valid", key_valid, e.kv);
            chk("aes_en_count", en_cnt, e.en);
            if (!e.launch)   chk("latency_err", mv_rise, e.acc + 2);
            else if (e.tmo)  chk("latency_tmo", mv_rise, en_cyc + TO + 1);
            else             chk("latency_done", mv_rise, done_cyc + 1);
          end
        end
        pmv = m_valid; pmr = m_ready; pblk = m_blk; pst = m_status;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] cmd, input logic [127:0] key, input logic [127:0] blk);
    int t = 0;
    @(posedge clk);
    #1;
    s_valid = 1'b1; s_cmd = cmd; s_key = key; s_blk = blk;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 400);
    if (!s_ready) begin
      chk("accept_timeout", s_ready, 1);
    end else begin
      sbq.push_back(model(cmd, key, blk));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_blk"}, m_blk, 0);
    chk({tag, "_m_status"}, m_status, 0);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_aes_en"}, aes_en, 0);
    chk({tag, "_aes_cmd"}, aes_cmd, 0);
    chk({tag, "_aes_key"}, aes_key, 0);
    chk({tag, "_aes_in_blk"}, aes_in_blk, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int t;
    int r;
    logic [31:0] c;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1);

    // encrypt before any key, then a bad command
    rdy_mode = 1;
    send(CMD_ENCRYPT, '0, FP);
    drain();
    send(32'hdeadbeef, rnd128(), rnd128());
    drain();

    // FIPS-197 flow
    send(CMD_SET_KEY, FK, rnd128());
    send(CMD_ENCRYPT, rnd128(), FP);
    send(CMD_DECRYPT, rnd128(), FC);
    drain();

    // backpressure with a spurious done while the response is held
    rdy_mode = 2;
    send(CMD_ENCRYPT, '0, rnd128());
    t = 0;
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid", m_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      spur_done = (i == 3);
    end
    spur_done = 1'b0;
    rdy_mode = 0;
    drain();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      c = $urandom;
      else if (r < 25) c = CMD_SET_KEY;
      else if (r < 62) c = CMD_ENCRYPT;
      else             c = CMD_DECRYPT;
      send(c, rnd128(), rnd128());
    end
    drain();
    rdy_mode = 1;

`ifdef AES_CTRL_WATCHDOG_EN
    send(CMD_SET_KEY, FK, '0);
    drain();
    core_hang = 1;
    send(CMD_ENCRYPT, '0, FP);
    drain();
    send(CMD_SET_KEY, rnd128(), '0);
    drain();
    core_hang = 0;
    send(CMD_ENCRYPT, '0, FP);
    send(CMD_SET_KEY, FK, '0);
    core_n_force = TO;
    send(CMD_ENCRYPT, '0, FP);
    drain();
    core_n_force = 0;
`endif

    // reset while waiting on the core
    send(CMD_SET_KEY, FK, '0);
    drain();
    core_n_force = 30;
    send(CMD_ENCRYPT, '0, FP);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_wait");
    sbq.delete();
    m_kv = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    core_n_force = 0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    send(CMD_ENCRYPT, '0, FP);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/aes_ctrl.md
# aes_ctrl

Request sequencer in front of the AES core (key expansion, encrypt, decrypt sharing one round-key RAM). It accepts one command at a time over a valid/ready request port and launches it on the core with a single-cycle enable. It then waits for the core's done pulse and returns the result block plus a status code over a valid/ready response port. It tracks whether a key has been loaded and rejects encrypt/decrypt otherwise.

## Interface
- TIMEOUT_CYCLES, 64: max WAIT cycles before aborting (used only with watchdog compiled in)
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  request valid
- s_ready  out  1  request accepted when s_valid & s_ready
- s_cmd  in  `WORD_S  command (`SET_KEY / `ENCRYPT / `DECRYPT)
- s_key  in  `KEY_S  key, used by `SET_KEY only
- s_blk  in  `BLK_S  input block
- m_valid  out  1  response valid
- m_ready  in  1  response consumed when m_valid & m_ready
- m_blk  out  `BLK_S  result block (zero for `SET_KEY and errors)
- m_status  out  2  0 OK, 1 BADCMD, 2 NOKEY, 3 TIMEOUT
- key_valid  out  1  a key expansion has completed successfully
- aes_en  out  1  one-cycle launch pulse to core
- aes_cmd / aes_key / aes_in_blk  out  `WORD_S / `KEY_S / `BLK_S  held operands to core
- aes_out_blk  in  `BLK_S  core result
- aes_en_o  in  1  core done pulse

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: s_ready=1; on accept, register cmd/key/blk into operand regs → ISSUE.
- ISSUE: if cmd not one of the three codes → RESP, status BADCMD, aes_en stays 0. If cmd is `ENCRYPT/`DECRYPT and key_valid=0 → RESP, status NOKEY, aes_en stays 0. Otherwise aes_en=1 for this cycle only → WAIT.
- WAIT: on aes_en_o, capture aes_out_blk into m_blk (`SET_KEY: m_blk=0, set key_valid) → RESP, status OK.
- RESP: m_valid=1, m_blk/m_status stable until m_ready; on handshake → IDLE.
- A `SET_KEY that is accepted clears key_valid at ISSUE (round-key RAM being overwritten); it is set again only on its completion.
- aes_cmd/aes_key/aes_in_blk hold the accepted operands from ISSUE until the next accept; zero after reset.
- aes_en_o outside WAIT is ignored.
- aes_en is decoded from the registered state; no combinational path from s_* to aes_*.

## Timing
- Reset values: s_ready=0 while reset is asserted, 1 in IDLE afterwards; m_valid=0, m_blk=0, m_status=0, key_valid=0, aes_en=0, all aes_* operands 0; state IDLE; watchdog counter 0.
- Accept at cycle 0 → aes_en at cycle 1 → core done at cycle 1+N → m_valid at cycle 2+N.
- Error paths: accept at cycle 0 → m_valid at cycle 2.
- Back-to-back: m_ready at cycle k → s_ready at cycle k+1; throughput one command per (N+3) cycles.
- m_ready held high before m_valid: the response still lasts at least one cycle.
- Reset mid-operation: immediate return to IDLE, outputs to reset values, key_valid cleared (core and RAM content treated as lost).

## Configuration
- AES_CTRL_WATCHDOG_EN defined: counter runs in WAIT. After TIMEOUT_CYCLES cycles without aes_en_o → RESP, status TIMEOUT, m_blk=0. A timed-out `SET_KEY leaves key_valid=0. aes_en_o on the expiry cycle wins (status OK).
- Undefined: no counter; WAIT persists until aes_en_o; status 3 never produced; TIMEOUT_CYCLES unused.

## Structure
- The shared header holds the command codes, `WORD_S/`KEY_S/`BLK_S, and the new status codes (`AES_ST_OK, `AES_ST_BADCMD, `AES_ST_NOKEY, `AES_ST_TIMEOUT) plus state encodings.
- One sub-module, aes_ctrl_timer (load/run/expire counter), instantiated only under AES_CTRL_WATCHDOG_EN.

## Test plan
- Encrypt before key: `ENCRYPT accepted after reset → aes_en never pulses, m_valid at cycle 2, m_status=2, m_blk=0.
- FIPS-197 flow: `SET_KEY 000102030405060708090a0b0c0d0e0f → status 0, key_valid=1; then `ENCRYPT 00112233445566778899aabbccddeeff → m_blk 69c4e0d86a7b0430d8cdb78070b4c55a; `DECRYPT of that result → the original plaintext.
- Bad command s_cmd=0xdeadbeef → no aes_en, m_status=1 at cycle 2; the next valid command proceeds normally.
- Backpressure: hold m_ready=0 for 10 cycles → m_valid/m_blk stable, s_ready=0 throughout; spurious aes_en_o in RESP is ignored.
- Watchdog (macro on, TIMEOUT_CYCLES=8): core model never returns done → m_status=3 exactly 8 cycles after aes_en. Repeat with done on cycle 8 → status 0.
- Reset asserted during WAIT → all outputs to reset values, key_valid=0; a subsequent `ENCRYPT returns NOKEY.
